uart_rx_nword: RTL

UART_RX_NWORD -- requirements
Module: uart_rx_nword

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx.sv | 114 +++++++++++
 rtl/uart_rx_nword.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path and word assembler.
package uart_pkg;

  typedef enum logic {
    ASM_IDLE    = 1'b0,
    ASM_COLLECT = 1'b1
  } asm_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  function automatic int clks_per_bit(input int clk_rate, input int baud);
    return (clk_rate * 1_000_000) / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver: samples each bit at its midpoint and emits a
// one-cycle strobe with the byte once a valid stop bit is seen.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       srx,
  output logic       rx_valid,
  output logic [7:0] rx_byte
);

  // state    | meaning
  // RX_IDLE  | line idle, waiting for falling edge of start bit
  // RX_START | waiting half a bit to confirm start bit is still low
  // RX_DATA  | sampling 8 data bits, LSB first, at bit centres
  // RX_STOP  | sampling stop bit; byte is strobed only if it is high

  localparam int CPB  = (CLKS_PER_BIT > 1) ? CLKS_PER_BIT : 2;
  localparam int TW   = $clog2(CPB);
  localparam int HALF = CPB / 2 - 1;

  logic            srx_meta_q, srx_sync_q;
  rx_state_e       state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            rx_valid_q, rx_valid_d;
  logic [7:0]      rx_byte_q, rx_byte_d;

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    rx_valid_d = 1'b0;
    rx_byte_d  = rx_byte_q;
    case (state_q)
      RX_IDLE: begin
        if (!srx_sync_q) begin
          state_d = RX_START;
          tmr_d   = TW'(HALF);
        end
      end
      RX_START: begin
        if (tmr_q == '0) begin
          if (!srx_sync_q) begin
            state_d   = RX_DATA;
            tmr_d     = TW'(CPB - 1);
            bit_idx_d = 3'd0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (tmr_q == '0) begin
          shift_d = {srx_sync_q, shift_q[7:1]};
          tmr_d   = TW'(CPB - 1);
          if (bit_idx_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (tmr_q == '0) begin
          state_d = RX_IDLE;
          // A low stop bit is a framing error; the byte is silently dropped.
          if (srx_sync_q) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = shift_q;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      srx_meta_q <= 1'b1;
      srx_sync_q <= 1'b1;
      state_q    <= RX_IDLE;
      tmr_q      <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= 8'd0;
    end else begin
      srx_meta_q <= srx;
      srx_sync_q <= srx_meta_q;
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      rx_valid_q <= rx_valid_d;
      rx_byte_q  <= rx_byte_d;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_byte  = rx_byte_q;

endmodule

// File: rtl/uart_rx_nword.sv
// Assembles NUM_BYTES received UART bytes into one word with a valid/ready
// output, an inter-byte timeout that discards partial words, and overrun flag.
module uart_rx_nword
  import uart_pkg::*;
#(
  parameter int CLK_RATE    = -1,
  parameter int BAUD        = -1,
  parameter int IB_TIMEOUT  = 200,
  parameter int TIMEOUT_OVR = 0,
  parameter int NUM_BYTES   = 4,
  parameter int BIG_ENDIAN  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   srx,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_word,
  output logic                   timeout_err,
  output logic                   overrun
);

  // state       | meaning
  // ASM_IDLE    | no bytes of the current word held
  // ASM_COLLECT | 1..NUM_BYTES-1 bytes held, timeout counter running

  localparam int WW           = 8 * NUM_BYTES;
  localparam int CPB          = clks_per_bit(CLK_RATE, BAUD);
  localparam int TIMEOUT_CLKS = (TIMEOUT_OVR != 0) ? TIMEOUT_OVR
                                                   : CLK_RATE * IB_TIMEOUT * 1000;
  localparam int TO_SAFE      = (TIMEOUT_CLKS > 0) ? TIMEOUT_CLKS : 1;
  localparam int TW           = $clog2(TO_SAFE + 1);
  localparam int CW           = $clog2(NUM_BYTES + 1);

  logic          rx_valid;
  logic [7:0]    rx_byte;

  asm_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [WW-1:0] asm_q, asm_d;
  logic [WW-1:0] out_word_q, out_word_d;
  logic          out_valid_q, out_valid_d;
  logic          timeout_err_q, timeout_err_d;
  logic          overrun_q, overrun_d;

  logic [WW-1:0] byte_ext;
  logic [WW-1:0] asm_shifted;
  logic          complete;

  uart_rx #(
    .CLKS_PER_BIT(CPB)
  ) u_rx (
    .clk     (clk),
    .rst     (rst),
    .srx     (srx),
    .rx_valid(rx_valid),
    .rx_byte (rx_byte)
  );

  // Shifting keeps the first byte moving toward the MSB (or LSB) so that
  // after NUM_BYTES strobes it lands in its final position.
  always_comb begin
    byte_ext = WW'(rx_byte);
    if (BIG_ENDIAN != 0) begin
      asm_shifted = (asm_q << 8) | byte_ext;
    end else begin
      asm_shifted = (asm_q >> 8) | (byte_ext << (WW - 8));
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tmr_d         = tmr_q;
    asm_d         = asm_q;
    out_word_d    = out_word_q;
    out_valid_d   = out_valid_q;
    timeout_err_d = 1'b0;
    overrun_d     = 1'b0;
    complete      = 1'b0;

    // A strobe always takes priority over a coincident timeout.
    if (rx_valid) begin
      tmr_d = '0;
      if (cnt_q == CW'(NUM_BYTES - 1)) begin
        complete = 1'b1;
        state_d  = ASM_IDLE;
        cnt_d    = '0;
        asm_d    = '0;
      end else begin
        state_d = ASM_COLLECT;
        cnt_d   = cnt_q + 1'b1;
        asm_d   = asm_shifted;
      end
    end else if (state_q == ASM_COLLECT) begin
      if (tmr_q == TW'(TO_SAFE)) begin
        state_d       = ASM_IDLE;
        cnt_d         = '0;
        tmr_d         = '0;
        asm_d         = '0;
        timeout_err_d = 1'b1;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end

    if (complete) begin
      if (!out_valid_q || out_ready) begin
        out_word_d  = asm_shifted;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ASM_IDLE;
      cnt_q         <= '0;
      tmr_q         <= '0;
      asm_q         <= '0;
      out_word_q    <= '0;
      out_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmr_q         <= tmr_d;
      asm_q         <= asm_d;
      out_word_q    <= out_word_d;
      out_valid_q   <= out_valid_d;
      timeout_err_q <= timeout_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_word    = out_word_q;
  assign timeout_err = timeout_err_q;
  assign overrun     = overrun_q;

endmodule
